// File: rtl/memory_stage_pkg.sv
// Shared Y86-64 constants for the memory stage: stat codes, icodes, register ids, FSM states.
package memory_stage_pkg;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE   = 4'hF;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

endpackage

// File: rtl/mem_op_decode.sv
// Combinational decode of the M-stage icode into memory direction, address and write data.
module mem_op_decode
  import memory_stage_pkg::*;
(
  input  logic [3:0]  icode_i,
  input  logic [63:0] valE_i,
  input  logic [63:0] valA_i,
  output logic        is_read_o,
  output logic        is_write_o,
  output logic [63:0] addr_o,
  output logic [63:0] wdata_o
);

  always_comb begin
    is_read_o  = 1'b0;
    is_write_o = 1'b0;
    addr_o     = valE_i;
    wdata_o    = valA_i;
    case (icode_i)
      IMRMOVQ: is_read_o = 1'b1;
      // Pops and returns read from the old stack pointer carried in valA.
      IPOPQ, IRET: begin
        is_read_o = 1'b1;
        addr_o    = valA_i;
      end
      IRMMOVQ, IPUSHQ, ICALL: is_write_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 M stage: 8-byte data access over a req/ack bus, stalls the pipe while outstanding.
// Optional MEM_TIMEOUT_EN adds a BUSY watchdog that aborts with SADR after TIMEOUT_CYCLES.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter logic [63:0] MEM_SIZE = 64'h2000
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  M_stat_i,
  input  logic [3:0]  M_icode_i,
  input  logic [63:0] M_valE_i,
  input  logic [63:0] M_valA_i,
  input  logic        M_stall_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [63:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [63:0] dmem_rdata_i,
  input  logic        dmem_err_i,
  output logic [63:0] m_valM_o,
  output logic [2:0]  m_stat_o,
  output logic        m_stall_req_o
);

  localparam logic [63:0] ADDR_MAX = MEM_SIZE - 64'd8;

  logic        is_read, is_write, is_mem, stat_ok, in_range, eligible;
  logic [63:0] acc_addr, acc_wdata;

  mem_op_decode u_decode (
    .icode_i    (M_icode_i),
    .valE_i     (M_valE_i),
    .valA_i     (M_valA_i),
    .is_read_o  (is_read),
    .is_write_o (is_write),
    .addr_o     (acc_addr),
    .wdata_o    (acc_wdata)
  );

  assign is_mem   = is_read | is_write;
  assign stat_ok  = (M_stat_i == SAOK);
  // Constant upper bound keeps the compare free of addr+8 overflow.
  assign in_range = (acc_addr <= ADDR_MAX);
  assign eligible = is_mem & stat_ok & in_range;

  ms_state_e   state_q;
  logic        req_q, we_q, err_q;
  logic [63:0] addr_q, wdata_q, valm_q;

`ifdef MEM_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] to_cnt_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MS_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      valm_q  <= '0;
      err_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        MS_IDLE: begin
          if (eligible) begin
            state_q <= MS_BUSY;
            req_q   <= 1'b1;
            we_q    <= is_write;
            addr_q  <= acc_addr;
            wdata_q <= acc_wdata;
`ifdef MEM_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end
        end
        MS_BUSY: begin
          if (dmem_ack_i) begin
            state_q <= MS_DONE;
            req_q   <= 1'b0;
            valm_q  <= dmem_rdata_i;
            err_q   <= dmem_err_i;
          end
`ifdef MEM_TIMEOUT_EN
          else if (to_cnt_q == TO_LAST) begin
            state_q <= MS_DONE;
            req_q   <= 1'b0;
            valm_q  <= '0;
            err_q   <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
          end
`endif
        end
        MS_DONE: begin
          if (!M_stall_i) state_q <= MS_IDLE;
        end
        default: state_q <= MS_IDLE;
      endcase
    end
  end

  always_comb begin
    m_valM_o = '0;
    m_stat_o = M_stat_i;
    if (state_q == MS_DONE) begin
      if (!we_q) m_valM_o = valm_q;
      if (err_q) m_stat_o = SADR;
    end else if (is_mem && stat_ok && !in_range) begin
      m_stat_o = SADR;
    end
  end

  assign m_stall_req_o = eligible & (state_q != MS_DONE);

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage; the bus responder is scripted per access.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic [63:0] M_valE, M_valA;
  logic        M_stall;
  logic        req, we;
  logic [63:0] addr, wdata;
  logic        ack;
  logic [63:0] rdata;
  logic        err;
  logic [63:0] valM;
  logic [2:0]  stat;
  logic        stall_req;

  int n_checks = 0;
  int n_pass   = 0;
  int stalls;
  logic [63:0] bus_addr, bus_wdata;
  logic        bus_we;

  always #5 clk = ~clk;

  memory_stage #(
    .MEM_SIZE(64'h2000)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .M_stat_i      (M_stat),
    .M_icode_i     (M_icode),
    .M_valE_i      (M_valE),
    .M_valA_i      (M_valA),
    .M_stall_i     (M_stall),
    .dmem_req_o    (req),
    .dmem_we_o     (we),
    .dmem_addr_o   (addr),
    .dmem_wdata_o  (wdata),
    .dmem_ack_i    (ack),
    .dmem_rdata_i  (rdata),
    .dmem_err_i    (err),
    .m_valM_o      (valM),
    .m_stat_o      (stat),
    .m_stall_req_o (stall_req)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic [2:0] s, input logic [3:0] ic,
                       input logic [63:0] ve, input logic [63:0] va);
    M_stat  = s;
    M_icode = ic;
    M_valE  = ve;
    M_valA  = va;
    #1;
  endtask

  // Let the pipe advance out of DONE and present a bubble.
  task automatic retire();
    step();
    set_m(SAOK, INOP, 64'd0, 64'd0);
  endtask

  // Counts stall cycles; acks on the ack_after-th BUSY cycle; records the bus request.
  task automatic run_access(input int ack_after, input logic [63:0] rd, input logic er,
                            output int n_stall, output logic [63:0] a,
                            output logic w, output logic [63:0] d);
    int busy = 0;
    n_stall = 0;
    a = '0; w = 1'b0; d = '0;
    for (int c = 0; c < 64; c++) begin
      if (!stall_req) break;
      n_stall++;
      if (req) begin
        busy++;
        if (busy == 1) begin
          a = addr; w = we; d = wdata;
        end
        if (busy == ack_after) begin
          ack = 1'b1; rdata = rd; err = er;
        end
      end
      step();
      ack = 1'b0; rdata = '0; err = 1'b0;
    end
    chk("access_released", stall_req, 1'b0);
  endtask

  initial begin
    rst = 1'b1; M_stall = 1'b0; ack = 1'b0; rdata = '0; err = 1'b0;
    set_m(SAOK, INOP, 64'd0, 64'd0);
    step(); step();
    chk("rst_req",   req,   1'b0);
    chk("rst_we",    we,    1'b0);
    chk("rst_addr",  addr,  64'd0);
    chk("rst_wdata", wdata, 64'd0);
    chk("rst_valM",  valM,  64'd0);
    chk("rst_stall", stall_req, 1'b0);
    rst = 1'b0;

    // Load with 3-cycle ack
    set_m(SAOK, IMRMOVQ, 64'h100, 64'd0);
    run_access(3, 64'hDEADBEEF, 1'b0, stalls, bus_addr, bus_we, bus_wdata);
    chk("ld_stalls", 64'(stalls), 64'd4);
    chk("ld_addr",   bus_addr, 64'h100);
    chk("ld_we",     bus_we, 1'b0);
    chk("ld_valM",   valM, 64'hDEADBEEF);
    chk("ld_stat",   stat, SAOK);
    chk("ld_req",    req, 1'b0);
    retire();

    // Push write
    set_m(SAOK, IPUSHQ, 64'h1F8, 64'h55);
    run_access(1, 64'hFFFF, 1'b0, stalls, bus_addr, bus_we, bus_wdata);
    chk("push_stalls", 64'(stalls), 64'd2);
    chk("push_addr",   bus_addr, 64'h1F8);
    chk("push_wdata",  bus_wdata, 64'h55);
    chk("push_we",     bus_we, 1'b1);
    chk("push_valM",   valM, 64'd0);
    chk("push_stat",   stat, SAOK);
    retire();

    // Out-of-range pop
    set_m(SAOK, IPOPQ, 64'd0, 64'h2000 - 64'd4);
    chk("oor_stat",  stat, SADR);
    chk("oor_stall", stall_req, 1'b0);
    chk("oor_valM",  valM, 64'd0);
    step();
    chk("oor_req",   req, 1'b0);

    // Address near 2^64 must not wrap into range
    set_m(SAOK, IRMMOVQ, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1);
    chk("wrap_stat",  stat, SADR);
    chk("wrap_stall", stall_req, 1'b0);
    step();
    chk("wrap_req",   req, 1'b0);

    // Highest legal address
    set_m(SAOK, IMRMOVQ, 64'h1FF8, 64'd0);
    run_access(1, 64'h77, 1'b0, stalls, bus_addr, bus_we, bus_wdata);
    chk("edge_stalls", 64'(stalls), 64'd2);
    chk("edge_addr",   bus_addr, 64'h1FF8);
    chk("edge_valM",   valM, 64'h77);
    retire();

    // Non-memory op and non-AOK stat pass straight through
    set_m(SAOK, IOPQ, 64'h123, 64'h456);
    chk("alu_stat",  stat, SAOK);
    chk("alu_stall", stall_req, 1'b0);
    chk("alu_valM",  valM, 64'd0);
    set_m(SHLT, IMRMOVQ, 64'h100, 64'd0);
    chk("hlt_stat",  stat, SHLT);
    chk("hlt_stall", stall_req, 1'b0);
    step();
    chk("hlt_req",   req, 1'b0);

    // Return with bus error, then held in DONE
    set_m(SAOK, IRET, 64'h999, 64'h40);
    run_access(1, 64'd0, 1'b1, stalls, bus_addr, bus_we, bus_wdata);
    chk("ret_addr", bus_addr, 64'h40);
    chk("ret_we",   bus_we, 1'b0);
    chk("ret_stat", stat, SADR);
    M_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("hold_stat",  stat, SADR);
      chk("hold_stall", stall_req, 1'b0);
      chk("hold_req",   req, 1'b0);
    end
    M_stall = 1'b0;
    retire();

    // Clean read after an errored one clears the error
    set_m(SAOK, IPOPQ, 64'h0, 64'h80);
    run_access(2, 64'h99, 1'b0, stalls, bus_addr, bus_we, bus_wdata);
    chk("pop_stalls", 64'(stalls), 64'd3);
    chk("pop_addr",   bus_addr, 64'h80);
    chk("pop_stat",   stat, SAOK);
    chk("pop_valM",   valM, 64'h99);
    retire();

    // Reset mid-BUSY, then a stray ack
    set_m(SAOK, IMRMOVQ, 64'h200, 64'd0);
    step();
    chk("busy_req", req, 1'b1);
    rst = 1'b1;
    step();
    chk("rstbusy_req", req, 1'b0);
    rst = 1'b0;
    set_m(SAOK, INOP, 64'd0, 64'd0);
    ack = 1'b1; rdata = 64'hBAD; err = 1'b1;
    step();
    ack = 1'b0; rdata = '0; err = 1'b0;
    chk("stray_req",   req, 1'b0);
    chk("stray_valM",  valM, 64'd0);
    chk("stray_stat",  stat, SAOK);
    chk("stray_stall", stall_req, 1'b0);

`ifdef MEM_TIMEOUT_EN
    set_m(SAOK, IMRMOVQ, 64'h300, 64'd0);
    run_access(1000, 64'd0, 1'b0, stalls, bus_addr, bus_we, bus_wdata);
    chk("to_stalls", 64'(stalls), 64'd9);
    chk("to_stat",   stat, SADR);
    chk("to_req",    req, 1'b0);
    retire();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
